// File: rtl/reg_bus_arb.sv
// Two-master to one-slave register bus arbiter: IDLE -> ACCESS -> RESP per transaction.
// Define REG_BUS_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module reg_bus_arb #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_done,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_done,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    output logic                  s_wen,
    output logic                  s_ren,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  win_q, win_d;
    logic                  we_q, we_d;
    logic                  mis_q, mis_d;
    logic [DATA_WIDTH-1:0] rcap_q, rcap_d;

    logic [ADDR_WIDTH-1:0] s_addr_d;
    logic [DATA_WIDTH-1:0] s_wdata_d;
    logic                  s_wen_d, s_ren_d, busy_d;
    logic                  m0_done_d, m0_err_d, m1_done_d, m1_err_d;
    logic [DATA_WIDTH-1:0] m0_rdata_d, m1_rdata_d;

    logic                  grant_c;
    logic                  sel_we_c;
    logic                  sel_mis_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_wdata_c;

`ifdef REG_BUS_ARB_RR_EN
    // prio_q names the master that wins a tie; it points away from the last winner
    logic prio_q, prio_d;

    always_comb begin
        if (m0_req && m1_req) begin
            grant_c = prio_q;
        end else begin
            grant_c = m1_req;
        end
    end
`else
    always_comb begin
        grant_c = !m0_req;
    end
`endif

    // Request mux for the winning master
    always_comb begin
        sel_we_c    = grant_c ? m1_we    : m0_we;
        sel_addr_c  = grant_c ? m1_addr  : m0_addr;
        sel_wdata_c = grant_c ? m1_wdata : m0_wdata;
        sel_mis_c   = (sel_addr_c[1:0] != 2'b00);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        we_d       = we_q;
        mis_d      = mis_q;
        rcap_d     = rcap_q;
        s_addr_d   = '0;
        s_wdata_d  = '0;
        s_wen_d    = 1'b0;
        s_ren_d    = 1'b0;
        busy_d     = 1'b0;
        m0_done_d  = 1'b0;
        m0_err_d   = 1'b0;
        m0_rdata_d = m0_rdata;
        m1_done_d  = 1'b0;
        m1_err_d   = 1'b0;
        m1_rdata_d = m1_rdata;
`ifdef REG_BUS_ARB_RR_EN
        prio_d     = prio_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d   = ACCESS;
                    win_d     = grant_c;
                    we_d      = sel_we_c;
                    mis_d     = sel_mis_c;
                    s_addr_d  = sel_addr_c;
                    s_wdata_d = sel_wdata_c;
                    s_wen_d   = sel_we_c && !sel_mis_c;
                    s_ren_d   = !sel_we_c && !sel_mis_c;
                    busy_d    = 1'b1;
                end
            end
            ACCESS: begin
                state_d = RESP;
                busy_d  = 1'b1;
                if (!we_q && !mis_q) begin
                    rcap_d = s_rdata;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!win_q) begin
                    m0_done_d = 1'b1;
                    m0_err_d  = mis_q;
                    if (!we_q && !mis_q) begin
                        m0_rdata_d = rcap_q;
                    end
                end else begin
                    m1_done_d = 1'b1;
                    m1_err_d  = mis_q;
                    if (!we_q && !mis_q) begin
                        m1_rdata_d = rcap_q;
                    end
                end
`ifdef REG_BUS_ARB_RR_EN
                prio_d = !win_q;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            mis_q    <= 1'b0;
            rcap_q   <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wen    <= 1'b0;
            s_ren    <= 1'b0;
            busy     <= 1'b0;
            m0_done  <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_done  <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
`ifdef REG_BUS_ARB_RR_EN
            prio_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            we_q     <= we_d;
            mis_q    <= mis_d;
            rcap_q   <= rcap_d;
            s_addr   <= s_addr_d;
            s_wdata  <= s_wdata_d;
            s_wen    <= s_wen_d;
            s_ren    <= s_ren_d;
            busy     <= busy_d;
            m0_done  <= m0_done_d;
            m0_err   <= m0_err_d;
            m0_rdata <= m0_rdata_d;
            m1_done  <= m1_done_d;
            m1_err   <= m1_err_d;
            m1_rdata <= m1_rdata_d;
`ifdef REG_BUS_ARB_RR_EN
            prio_q   <= prio_d;
`endif
        end
    end

endmodule

// File: tb/tb_reg_bus_arb.sv
// Scoreboard bench for reg_bus_arb; grant-order expectations follow REG_BUS_ARB_RR_EN.
module tb_reg_bus_arb;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } slv_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          done_a [2];
    logic          err_a  [2];
    logic [DW-1:0] rdata_a[2];

    logic          m0_done, m0_err, m1_done, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic          s_wen, s_ren, busy;

    reg_bus_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen), .s_ren(s_ren),
        .s_rdata(s_rdata), .busy(busy)
    );

    assign done_a[0]  = m0_done;
    assign done_a[1]  = m1_done;
    assign err_a[0]   = m0_err;
    assign err_a[1]   = m1_err;
    assign rdata_a[0] = m0_rdata;
    assign rdata_a[1] = m1_rdata;

    // Register-file slave: combinational read, write on the strobe edge
    logic [DW-1:0] slv_mem [64];
    assign s_rdata = s_ren ? slv_mem[s_addr[7:2]] : '0;
    always @(posedge clk) if (s_wen) slv_mem[s_addr[7:2]] <= s_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t          exp_q0[$], exp_q1[$];
    slv_t          slv_q0[$], slv_q1[$];
    int            order_q[$], done_cyc_q[$];
    logic [DW-1:0] ref_mem   [64];
    logic [DW-1:0] pred_rdata[2];
    logic [DW-1:0] hold      [2];
    int            done_cnt  [2];
    int            issued    [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on each done and each slave strobe
    always @(negedge clk) begin
        exp_t e;
        slv_t o;
        if (!reset_n) begin
            hold[0] = '0;
            hold[1] = '0;
            exp_q0.delete();
            exp_q1.delete();
            slv_q0.delete();
            slv_q1.delete();
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (done_a[m]) begin
                    if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
                        check("done_unexpected", 64'(m + 1), 64'(0));
                    end else begin
                        if (m == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        check("done_err", 64'(err_a[m]), 64'(e.err));
                        check("done_rdata", 64'(rdata_a[m]), 64'(e.rdata));
                        hold[m] = e.rdata;
                        done_cnt[m]++;
                        order_q.push_back(m);
                        done_cyc_q.push_back(cyc);
                    end
                end else begin
                    check("err_without_done", 64'(err_a[m]), 64'(0));
                    check("rdata_hold", 64'(rdata_a[m]), 64'(hold[m]));
                end
            end
            if (s_wen || s_ren) begin
                o.addr  = s_addr;
                o.we    = s_wen;
                o.wdata = s_wen ? s_wdata : '0;
                check("strobe_exclusive", 64'(s_wen & s_ren), 64'(0));
                if (slv_q0.size() > 0 && slv_q0[0] == o) begin
                    check("slave_access", 64'(o), 64'(slv_q0[0]));
                    void'(slv_q0.pop_front());
                end else if (slv_q1.size() > 0) begin
                    check("slave_access", 64'(o), 64'(slv_q1[0]));
                    void'(slv_q1.pop_front());
                end else if (slv_q0.size() > 0) begin
                    check("slave_access", 64'(o), 64'(slv_q0[0]));
                    void'(slv_q0.pop_front());
                end else begin
                    check("slave_unexpected", 64'(o), 64'(0));
                end
            end else if (!busy) begin
                check("s_addr_idle", 64'(s_addr), 64'(0));
                check("s_wdata_idle", 64'(s_wdata), 64'(0));
            end
        end
    end

    // One master transaction: predict, push expectations, drive, wait for done
    task automatic run_txn(input int m, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit drop_early, input bit keep,
                           input int exp_lat);
        exp_t e;
        slv_t s;
        logic mis;
        int   cnt;
        mis = (a[1:0] != 2'b00);
        if (!w && !mis) pred_rdata[m] = ref_mem[a[7:2]];
        if (w && !mis) ref_mem[a[7:2]] = d;
        e.err   = mis;
        e.rdata = pred_rdata[m];
        s.addr  = a;
        s.we    = w;
        s.wdata = w ? d : '0;
        if (m == 0) begin
            exp_q0.push_back(e);
            if (!mis) slv_q0.push_back(s);
        end else begin
            exp_q1.push_back(e);
            if (!mis) slv_q1.push_back(s);
        end
        issued[m]++;
        req[m]   = 1'b1;
        we[m]    = w;
        addr[m]  = a;
        wdata[m] = d;
        cnt = 0;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (drop_early && cnt == 1) req[m] = 1'b0;
            if (done_a[m]) break;
        end
        if (!done_a[m]) check("done_timeout", 64'(cnt), 64'(0));
        else if (exp_lat > 0) check("done_latency", 64'(cnt), 64'(exp_lat));
        if (!keep) req[m] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int exp_order[6];
    int base;
    int cnt_before;

    initial begin
`ifdef REG_BUS_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 1, 1, 1};
`endif
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
            pred_rdata[m] = '0; hold[m] = '0; done_cnt[m] = 0; issued[m] = 0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m0_done", 64'(m0_done), 64'(0));
        check("rst_m0_err", 64'(m0_err), 64'(0));
        check("rst_m0_rdata", 64'(m0_rdata), 64'(0));
        check("rst_m1_done", 64'(m1_done), 64'(0));
        check("rst_m1_err", 64'(m1_err), 64'(0));
        check("rst_m1_rdata", 64'(m1_rdata), 64'(0));
        check("rst_s_wen", 64'(s_wen), 64'(0));
        check("rst_s_ren", 64'(s_ren), 64'(0));
        check("rst_s_addr", 64'(s_addr), 64'(0));
        check("rst_s_wdata", 64'(s_wdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(2);

        // Basic writes, reads, and read-data hold
        run_txn(0, 1'b1, 8'h00, 32'hA5A5_0001, 0, 0, 3);
        run_txn(0, 1'b1, 8'h04, 32'h0000_00FF, 0, 0, 3);
        run_txn(1, 1'b0, 8'h04, 32'h0, 0, 0, 3);
        idle_cycles(2);
        run_txn(0, 1'b0, 8'h00, 32'h0, 0, 0, 3);

        // Misaligned accesses: error, no strobe, read data untouched
        run_txn(0, 1'b1, 8'h02, 32'hDEAD_BEEF, 0, 0, 3);
        run_txn(1, 1'b0, 8'h05, 32'h0, 0, 0, 3);

        // Request dropped right after sampling still completes once
        cnt_before = done_cnt[0];
        run_txn(0, 1'b1, 8'h08, 32'h1234_5678, 1, 0, 3);
        idle_cycles(6);
        check("drop_done_once", 64'(done_cnt[0] - cnt_before), 64'(1));
        run_txn(1, 1'b0, 8'h08, 32'h0, 0, 0, 3);

        // Both masters requesting back to back
        idle_cycles(1);
        base = order_q.size();
        fork
            begin
                for (int i = 0; i < 3; i++)
                    run_txn(0, 1'b1, AW'(8'h10 + 4 * i), 32'hC0DE_0000 + DW'(i), 0, (i < 2), 0);
            end
            begin
                for (int i = 0; i < 3; i++)
                    run_txn(1, 1'b0, AW'(8'h00 + 4 * i), 32'h0, 0, (i < 2), 0);
            end
        join
        idle_cycles(2);
        check("contend_count", 64'(order_q.size() - base), 64'(6));
        if (order_q.size() >= base + 6) begin
            for (int k = 0; k < 6; k++)
                check("grant_order", 64'(order_q[base + k]), 64'(exp_order[k]));
            for (int k = 0; k < 5; k++)
                check("grant_spacing", 64'(done_cyc_q[base + k + 1] - done_cyc_q[base + k]), 64'(3));
        end

        // Reset during the ACCESS cycle of an m1 read
        cnt_before = done_cnt[1];
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h04;
        @(posedge clk);
        #1;
        check("busy_in_access", 64'(busy), 64'(1));
        check("ren_in_access", 64'(s_ren), 64'(1));
        reset_n = 1'b0;
        #1;
        check("busy_after_rst", 64'(busy), 64'(0));
        check("ren_after_rst", 64'(s_ren), 64'(0));
        check("m1_rdata_after_rst", 64'(m1_rdata), 64'(0));
        req[1] = 1'b0;
        pred_rdata[0] = '0;
        pred_rdata[1] = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(5);
        check("no_done_after_rst", 64'(done_cnt[1] - cnt_before), 64'(0));
        run_txn(1, 1'b0, 8'h04, 32'h0, 0, 0, 3);
        idle_cycles(3);

        check("m0_total_done", 64'(done_cnt[0]), 64'(issued[0]));
        check("m1_total_done", 64'(done_cnt[1]), 64'(issued[1]));
        check("exp_q_empty", 64'(exp_q0.size() + exp_q1.size()), 64'(0));
        check("slv_q_empty", 64'(slv_q0.size() + slv_q1.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
